// File: rtl/fu_issue_arb_if.sv
// Issue-arbiter handshake bundle: per-bank ready requests from the RS banks,
// per-bank grants and writeback/busy status back from the arbiter.
interface fu_issue_arb_if;
  logic [1:0] alu_req;
  logic [1:0] mem_req;
  logic [1:0] mult_req;
  logic       mem_done;
  logic       flush;
  logic [1:0] alu_gnt;
  logic [1:0] mem_gnt;
  logic [1:0] mult_gnt;
  logic       mult_wb_valid;
  logic       mem_busy;

  modport master (
    output alu_req, mem_req, mult_req, mem_done, flush,
    input  alu_gnt, mem_gnt, mult_gnt, mult_wb_valid, mem_busy
  );

  modport slave (
    input  alu_req, mem_req, mult_req, mem_done, flush,
    output alu_gnt, mem_gnt, mult_gnt, mult_wb_valid, mem_busy
  );
endinterface

// File: rtl/fu_issue_arb.sv
// Two-bank functional-unit issue arbiter: combinational grants with mult > mem > alu
// class priority, per-class round-robin pointers and CDB slot reservation for multiplies.
module fu_issue_arb #(
  parameter int MULT_LAT = 4,
  parameter int CDB_W    = 2
) (
  input logic          clk,
  input logic          reset,
  fu_issue_arb_if.slave bus
);

  logic [MULT_LAT-1:0] occ;
  logic                mem_busy_q;
  logic                alu_ptr, mem_ptr, mult_ptr;

  logic [1:0] mult_g, mem_g, alu_g;
  logic [1:0] mem_cand, alu_cand;
  logic [1:0] alu_slots;
  logic       mult_contest, mem_contest, alu_contest;

  // Both candidates present: the pointer names the winner; otherwise the lone candidate wins.
  function automatic logic [1:0] pick(input logic [1:0] cand, input logic ptr);
    if (cand == 2'b11) return ptr ? 2'b10 : 2'b01;
    return cand;
  endfunction

  assign alu_slots = 2'(CDB_W) - {1'b0, occ[1]};

  always_comb begin
    mult_g       = '0;
    mem_g        = '0;
    alu_g        = '0;
    mem_cand     = '0;
    alu_cand     = '0;
    mult_contest = 1'b0;
    mem_contest  = 1'b0;
    alu_contest  = 1'b0;
    if (!reset && !bus.flush) begin
      mult_g       = pick(bus.mult_req, mult_ptr);
      mult_contest = (bus.mult_req == 2'b11);
      mem_cand     = bus.mem_req & ~mult_g;
      // Memory FU frees up in the same cycle it reports done.
      if (!mem_busy_q || bus.mem_done) begin
        mem_g       = pick(mem_cand, mem_ptr);
        mem_contest = (mem_cand == 2'b11);
      end
      alu_cand = bus.alu_req & ~mult_g & ~mem_g;
      if (alu_slots >= 2'd2) begin
        alu_g = alu_cand;
      end else begin
        alu_g       = pick(alu_cand, alu_ptr);
        alu_contest = (alu_cand == 2'b11);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ        <= '0;
      mem_busy_q <= 1'b0;
      alu_ptr    <= 1'b0;
      mem_ptr    <= 1'b0;
      mult_ptr   <= 1'b0;
    end else begin
      if (bus.flush) occ <= '0;
      else           occ <= {|mult_g, occ[MULT_LAT-1:1]};

      if (|mem_g)            mem_busy_q <= 1'b1;
      else if (bus.mem_done) mem_busy_q <= 1'b0;

      // A contested grant goes to the pointer's bank, so the loser is ~ptr.
      if (mult_contest) mult_ptr <= ~mult_ptr;
      if (mem_contest)  mem_ptr  <= ~mem_ptr;
      if (alu_contest)  alu_ptr  <= ~alu_ptr;
    end
  end

  assign bus.mult_gnt      = mult_g;
  assign bus.mem_gnt       = mem_g;
  assign bus.alu_gnt       = alu_g;
  assign bus.mult_wb_valid = occ[0];
  assign bus.mem_busy      = mem_busy_q;

endmodule

// File: tb/tb_fu_issue_arb.sv
// Scoreboard bench for fu_issue_arb: the driver pushes hand-computed expectations per
// cycle, a negedge monitor pops and compares them against the DUT outputs.
module tb_fu_issue_arb;

  logic clk;
  logic reset;
  fu_issue_arb_if bus ();

  fu_issue_arb #(.MULT_LAT(4), .CDB_W(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] alu;
    logic [1:0] mem;
    logic [1:0] mult;
    logic       wb;
    logic       busy;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: compare every queued expectation half a cycle after it was issued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({bus.alu_gnt, bus.mem_gnt, bus.mult_gnt, bus.mult_wb_valid, bus.mem_busy} !==
            {e.alu, e.mem, e.mult, e.wb, e.busy}) begin
          errors++;
          $display("FAIL %s: got alu=%b mem=%b mult=%b wb=%b busy=%b, expected alu=%b mem=%b mult=%b wb=%b busy=%b",
                   e.name, bus.alu_gnt, bus.mem_gnt, bus.mult_gnt, bus.mult_wb_valid, bus.mem_busy,
                   e.alu, e.mem, e.mult, e.wb, e.busy);
        end
      end
    end
  end

  task automatic vec(input logic rst, input logic [1:0] alu, input logic [1:0] mem,
                     input logic [1:0] mult, input logic done, input logic fl,
                     input logic [1:0] e_alu, input logic [1:0] e_mem, input logic [1:0] e_mult,
                     input logic e_wb, input logic e_busy, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = rst;
    bus.alu_req  = alu;
    bus.mem_req  = mem;
    bus.mult_req = mult;
    bus.mem_done = done;
    bus.flush    = fl;
    e.alu  = e_alu;
    e.mem  = e_mem;
    e.mult = e_mult;
    e.wb   = e_wb;
    e.busy = e_busy;
    e.name = name;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected completion before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    bus.alu_req  = '0;
    bus.mem_req  = '0;
    bus.mult_req = '0;
    bus.mem_done = 1'b0;
    bus.flush    = 1'b0;

    //   rst alu    mem    mult   done fl   e_alu  e_mem  e_mult wb busy
    vec(1, 2'b11, 2'b11, 2'b11, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, "reset_gates_grants");
    // Contested mults alternate; two writebacks land 4 and 5 cycles later.
    vec(0, 2'b00, 2'b00, 2'b11, 0, 0, 2'b00, 2'b00, 2'b01, 0, 0, "mult_rr_first");
    vec(0, 2'b00, 2'b00, 2'b11, 0, 0, 2'b00, 2'b00, 2'b10, 0, 0, "mult_rr_second");
    vec(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, "idle_t2");
    vec(0, 2'b11, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, "alu_one_slot_ptr0");
    vec(0, 2'b11, 2'b00, 2'b00, 0, 0, 2'b10, 2'b00, 2'b00, 1, 0, "alu_one_slot_ptr1_wb1");
    vec(0, 2'b11, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 2'b00, 1, 0, "alu_two_slots_wb2");
    vec(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, "wb_done");
    // Single mult: ALU squeezed to one slot at t+3, full again at t+4.
    vec(0, 2'b00, 2'b00, 2'b01, 0, 0, 2'b00, 2'b00, 2'b01, 0, 0, "mult_single");
    vec(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, "idle_s1");
    vec(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, "idle_s2");
    vec(0, 2'b11, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, "alu_t3_one_slot");
    vec(0, 2'b11, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 2'b00, 1, 0, "alu_t4_two_slots");
    // One grant per bank, mult wins.
    vec(0, 2'b01, 2'b01, 2'b01, 0, 0, 2'b00, 2'b00, 2'b01, 0, 0, "class_priority");
    vec(0, 2'b00, 2'b01, 2'b00, 0, 0, 2'b00, 2'b01, 2'b00, 0, 0, "mem_grant_b0");
    vec(0, 2'b00, 2'b10, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, "mem_blocked_busy");
    vec(0, 2'b00, 2'b10, 2'b00, 1, 0, 2'b00, 2'b10, 2'b00, 0, 1, "mem_reuse_on_done");
    vec(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 1, "mem_busy_holds");
    vec(0, 2'b00, 2'b11, 2'b00, 1, 0, 2'b00, 2'b01, 2'b00, 0, 1, "mem_rr_first");
    vec(0, 2'b00, 2'b11, 2'b00, 1, 0, 2'b00, 2'b10, 2'b00, 0, 1, "mem_rr_second");
    // Flush squashes in-flight multiplies and leaves mem_busy alone.
    vec(0, 2'b00, 2'b00, 2'b01, 0, 0, 2'b00, 2'b00, 2'b01, 0, 1, "flush_mult_t");
    vec(0, 2'b00, 2'b00, 2'b01, 0, 0, 2'b00, 2'b00, 2'b01, 0, 1, "flush_mult_t1");
    vec(0, 2'b11, 2'b11, 2'b11, 0, 1, 2'b00, 2'b00, 2'b00, 0, 1, "flush_kills_grants");
    for (int i = 0; i < 4; i++)
      vec(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, $sformatf("flush_no_wb_%0d", i));
    vec(0, 2'b00, 2'b01, 2'b00, 1, 1, 2'b00, 2'b00, 2'b00, 0, 1, "flush_with_done");
    vec(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, "busy_cleared_by_done");
    // Async reset mid-flight, then pointers must start from bank 0.
    vec(0, 2'b00, 2'b01, 2'b00, 0, 0, 2'b00, 2'b01, 2'b00, 0, 0, "pre_reset_mem");
    vec(0, 2'b00, 2'b00, 2'b01, 0, 0, 2'b00, 2'b00, 2'b01, 0, 1, "pre_reset_mult");
    vec(1, 2'b11, 2'b11, 2'b11, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, "async_reset_midcycle");
    vec(0, 2'b00, 2'b00, 2'b11, 0, 0, 2'b00, 2'b00, 2'b01, 0, 0, "post_reset_mult_ptr0");
    vec(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, "post_idle1");
    vec(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, "post_idle2");
    vec(0, 2'b11, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, "post_reset_alu_ptr0");
    vec(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0, "post_reset_wb");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fu_issue_arb.md
FU_ISSUE_ARB -- requirements
Module: fu_issue_arb

Interface
REQ-001 Parameter MULT_LAT, default 4, multiplier issue-to-CDB latency in cycles; legal range 2..8.
REQ-002 Parameter CDB_W, default 2, CDB broadcast slots per cycle; fixed at 2 for this revision.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 alu_req  input  2  bit i: RS bank i has a ready ALU entry.
REQ-006 mem_req  input  2  bit i: RS bank i has a ready memory entry.
REQ-007 mult_req  input  2  bit i: RS bank i has a ready multiply entry.
REQ-008 mem_done  input  1  memory FU completes its in-flight op this cycle.
REQ-009 flush  input  1  branch mispredict squash.
REQ-010 alu_gnt  output  2  bit i: bank i issues to an ALU this cycle.
REQ-011 mem_gnt  output  2  bit i: bank i issues to the memory FU this cycle.
REQ-012 mult_gnt  output  2  bit i: bank i issues to the multiplier this cycle.
REQ-013 mult_wb_valid  output  1  a multiply result occupies one CDB slot this cycle.
REQ-014 mem_busy  output  1  memory FU holds an un-completed op.

Function
REQ-015 Grants SHALL be combinational from the current-cycle requests and registered state; there are no registered grants.
REQ-016 Each bank SHALL receive at most one grant per cycle, with class priority mult > mem > alu.
REQ-017 Multiplier: at most one mult_gnt per cycle, and the multiplier is never blocked except by flush.
REQ-018 Memory: at most one mem_gnt per cycle, allowed only when mem_busy=0 or mem_done=1 (same-cycle reuse); candidates exclude any bank already granted mult.
REQ-019 Occupancy vector occ[MULT_LAT-1:0] SHALL track writebacks: bit j = a multiply writes back j cycles from now.
REQ-020 Each cycle, occ[j] <= occ[j+1] for j < MULT_LAT-1, and occ[MULT_LAT-1] <= |mult_gnt.
REQ-021 mult_wb_valid SHALL equal occ[0], so a grant at cycle t gives mult_wb_valid=1 at t+MULT_LAT.
REQ-022 ALU: results reach the CDB at t+1; ALU slots available = CDB_W - occ[1].
REQ-023 ALU: candidates are banks with alu_req and no other grant this cycle.
REQ-024 ALU: with 2 slots, grant all candidates; with 1 slot and 2 candidates, grant per alu_ptr.
REQ-025 Each class (alu, mem, mult) SHALL keep a 1-bit round-robin pointer naming the preferred bank.
REQ-026 On a contested grant (both banks are candidates and one is chosen), the pointer SHALL flip to the loser.
REQ-027 Uncontested grants and idle cycles SHALL leave the pointer unchanged.
REQ-028 mem_busy next state: 1 if mem_gnt!=0, else 0 if mem_done, else hold; mem_done with mem_busy=0 is ignored.
REQ-029 flush=1 SHALL force all grants to 0 that cycle and clear occ to 0 on the next edge.
REQ-030 flush SHALL NOT change mem_busy or the pointers.
REQ-031 flush with mem_done in the same cycle SHALL clear mem_busy per REQ-028.
REQ-032 Requests from a bank that is not granted SHALL carry no state; the RS re-presents them next cycle.

Reset
REQ-033 reset=1 SHALL immediately (asynchronously) clear occ, mem_busy and all pointers to 0.
REQ-034 While reset=1, all grant outputs and mult_wb_valid SHALL be 0.
REQ-035 Reset asserted mid-operation SHALL discard in-flight multiply writebacks and memory busy state.
REQ-036 First edge after reset deassertion SHALL behave as an idle machine with all pointers selecting bank 0.

Verification
REQ-037 After reset, drive mult_req=11 for 1 cycle -> mult_gnt=01 and mult_ptr=1. Drive 11 again -> mult_gnt=10. Expect mult_wb_valid=1 at cycles t+4 and t+5 (MULT_LAT=4).
REQ-038 Issue a mult at t, then at t+3 drive alu_req=11 -> exactly one alu_gnt bit, chosen per alu_ptr. At t+4, alu_req=11 -> alu_gnt=11.
REQ-039 mem_req=01 -> mem_gnt=01 and mem_busy=1 next cycle. Then mem_req=10 with mem_done=0 -> mem_gnt=00. Then mem_req=10 with mem_done=1 -> mem_gnt=10 and mem_busy stays 1.
REQ-040 Bank 0 drives mult_req=1, mem_req=1, alu_req=1 and bank 1 is idle -> mult_gnt=01, mem_gnt=00, alu_gnt=00.
REQ-041 Issue mults at t and t+1, then flush=1 at t+2 -> grants 00 at t+2, and mult_wb_valid never asserts. mem_busy is unchanged.
REQ-042 Assert reset asynchronously with occ!=0 and mem_busy=1 -> outputs drop to 0 before the next edge; after release, the first contested ALU request grants bank 0.
